cmp_share_arbiter: RTL

CMP_SHARE_ARBITER -- requirements
Module: cmp_share_arbiter

---
 rtl/cmp_pkg.sv | 22 ++
 rtl/cmp_core.sv | 26 ++
 rtl/cmp_share_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared types for the compare-share arbiter: result-slot FSM states, compare outcome,
// statistics counter width and a saturating increment helper.
package cmp_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } cmp_state_t;

    typedef enum logic [1:0] {
        EQ = 2'd0,
        GT = 2'd1,
        LT = 2'd2
    } cmp_res_t;

    localparam int unsigned CMP_STAT_W = 16;

    function automatic logic [CMP_STAT_W-1:0] sat_inc(input logic [CMP_STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cmp_core.sv
// Combinational signed three-way compare of two WIDTH-bit operands.
module cmp_core
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output cmp_res_t         o_res
);

    // One extra bit keeps the difference of the extreme operands from wrapping.
    logic [WIDTH:0] w_diff;

    assign w_diff = {i_a[WIDTH-1], i_a} - {i_b[WIDTH-1], i_b};

    always_comb begin
        o_res = GT;
        if (w_diff == '0) begin
            o_res = EQ;
        end else if (w_diff[WIDTH]) begin
            o_res = LT;
        end
    end

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one signed comparator among NREQ requesters, with a
// single registered result slot. Define CMP_SHARE_STATS_EN to add saturating result counters.
module cmp_share_arbiter
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   a_bus,
    input  logic [NREQ*WIDTH-1:0]   b_bus,
    output logic [NREQ-1:0]         gnt,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [$clog2(NREQ)-1:0] res_id,
    output logic                    res_equal,
    output logic                    res_greater,
    output logic                    res_lower
`ifdef CMP_SHARE_STATS_EN
   ,output logic [CMP_STAT_W-1:0]   cnt_eq,
    output logic [CMP_STAT_W-1:0]   cnt_gt,
    output logic [CMP_STAT_W-1:0]   cnt_lt
`endif
);

    localparam int IDW = $clog2(NREQ);

    cmp_state_t     r_state;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_id;
    logic           r_eq;
    logic           r_gt;
    logic           r_lt;

    logic [IDW-1:0]   w_idx;
    logic [IDW-1:0]   w_cand;
    logic [IDW-1:0]   w_ptr_nxt;
    logic             w_found;
    logic             w_grant;
    logic [NREQ-1:0]  w_gnt;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    cmp_res_t         w_cmp;
    int               w_j;

    // Scan from the top down so the last hit is the first set bit at or above r_ptr.
    always_comb begin
        w_idx   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_j = int'(r_ptr) + k;
            if (w_j >= NREQ) begin
                w_j = w_j - NREQ;
            end
            w_cand = IDW'(w_j);
            if (req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
        w_a = '0;
        w_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_idx == IDW'(k)) begin
                w_a = a_bus[k*WIDTH +: WIDTH];
                w_b = b_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    // A grant needs a free slot: empty now, or being consumed on this edge.
    assign w_grant   = w_found && !rst && ((r_state == EMPTY) || res_ready);
    assign w_ptr_nxt = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

    always_comb begin
        w_gnt        = '0;
        w_gnt[w_idx] = w_grant;
    end

    cmp_core #(
        .WIDTH (WIDTH)
    ) u_cmp_core (
        .i_a   (w_a),
        .i_b   (w_b),
        .o_res (w_cmp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_ptr   <= '0;
            r_id    <= '0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            if (w_grant) begin
                r_ptr <= w_ptr_nxt;
                r_id  <= w_idx;
                r_eq  <= (w_cmp == EQ);
                r_gt  <= (w_cmp == GT);
                r_lt  <= (w_cmp == LT);
            end
            unique case (r_state)
                EMPTY: begin
                    if (w_grant) begin
                        r_state <= FULL;
                    end
                end
                FULL: begin
                    if (res_ready && !w_grant) begin
                        r_state <= EMPTY;
                        r_eq    <= 1'b0;
                        r_gt    <= 1'b0;
                        r_lt    <= 1'b0;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign gnt         = w_gnt;
    assign res_valid   = (r_state == FULL);
    assign res_id      = r_id;
    assign res_equal   = r_eq;
    assign res_greater = r_gt;
    assign res_lower   = r_lt;

`ifdef CMP_SHARE_STATS_EN
    logic                  w_consume;
    logic [CMP_STAT_W-1:0] r_cnt_eq;
    logic [CMP_STAT_W-1:0] r_cnt_gt;
    logic [CMP_STAT_W-1:0] r_cnt_lt;

    assign w_consume = (r_state == FULL) && res_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_eq <= '0;
            r_cnt_gt <= '0;
            r_cnt_lt <= '0;
        end else if (w_consume) begin
            if (r_eq) r_cnt_eq <= sat_inc(r_cnt_eq);
            if (r_gt) r_cnt_gt <= sat_inc(r_cnt_gt);
            if (r_lt) r_cnt_lt <= sat_inc(r_cnt_lt);
        end
    end

    assign cnt_eq = r_cnt_eq;
    assign cnt_gt = r_cnt_gt;
    assign cnt_lt = r_cnt_lt;
`endif

endmodule
